// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the HI/LO multi-cycle scheduler: op encodings,
// scheduler state encodings, handshake constants and op-decoding helpers.
package muldiv_sched_pkg;

    localparam int WORD_W = 32;

    typedef logic [2:0] op_t;

    // op_i encodings; bit 0 clear marks the signed flavour of each pair
    localparam op_t OP_MULT  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_MADD  = 3'd2;
    localparam op_t OP_MADDU = 3'd3;
    localparam op_t OP_MSUB  = 3'd4;
    localparam op_t OP_MSUBU = 3'd5;
    localparam op_t OP_DIV   = 3'd6;
    localparam op_t OP_DIVU  = 3'd7;

    // Scheduler state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MUL      = 3'd1;
    localparam logic [2:0] ST_ACC      = 3'd2;
    localparam logic [2:0] ST_DIV_ZERO = 3'd3;
    localparam logic [2:0] ST_DIV_ON   = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic STOP                 = 1'b1;
    localparam logic NO_STOP              = 1'b0;

    localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic is_signed_op(input op_t op);
        return (op[0] == 1'b0);
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc_op(input op_t op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub_op(input op_t op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Request/result bundle between the EX stage and the HI/LO scheduler.
interface muldiv_sched_if #(
    parameter int DATA_W = 32
);
    logic                start_i;
    logic [2:0]          op_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic [2*DATA_W-1:0] hilo_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;
    logic                stallreq_o;

    // Requester side (EX stage)
    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    // Scheduler side
    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/muldiv_sched_div_core.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up applied on the way out. Divide-by-zero short-circuits to 0.
module muldiv_sched_div_core
    import muldiv_sched_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DIV_ITER = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_op,
    input  logic                annul,
    input  logic [DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]   divisor,
    output logic                ready,
    output logic [2*DATA_W-1:0] result
);
    localparam int CNT_W = $clog2(DIV_ITER) + 1;

    localparam logic [1:0] DC_IDLE = 2'd0;
    localparam logic [1:0] DC_ZERO = 2'd1;
    localparam logic [1:0] DC_ON   = 2'd2;
    localparam logic [1:0] DC_END  = 2'd3;

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] dsor_r;
    logic              neg_q_r;
    logic              neg_r_r;

    logic [DATA_W-1:0] dividend_mag_s;
    logic [DATA_W-1:0] divisor_mag_s;
    logic [DATA_W:0]   shifted_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] quo_fix_s;
    logic [DATA_W-1:0] rem_fix_s;

    // Operand magnitudes, trial subtraction on the 33-bit shifted remainder, sign fix-up
    always_comb begin
        dividend_mag_s = dividend;
        divisor_mag_s  = divisor;
        if (signed_op && dividend[DATA_W-1]) begin
            dividend_mag_s = -dividend;
        end else begin
            dividend_mag_s = dividend;
        end
        if (signed_op && divisor[DATA_W-1]) begin
            divisor_mag_s = -divisor;
        end else begin
            divisor_mag_s = divisor;
        end
        shifted_s = {rem_r, quo_r[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, dsor_r};
        quo_fix_s = neg_q_r ? -quo_r : quo_r;
        rem_fix_s = neg_r_r ? -rem_r : rem_r;
    end

    // Result presented for exactly one cycle, in the zero or end state
    assign ready  = ((state_r == DC_ZERO) || (state_r == DC_END)) ? DIV_RESULT_READY
                                                                  : DIV_RESULT_NOT_READY;
    assign result = (state_r == DC_ZERO) ? {ZERO_WORD, ZERO_WORD} : {rem_fix_s, quo_fix_s};

    // Divider sequencing: launch, one restoring step per cycle, abandon on annul
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DC_IDLE;
            cnt_r   <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dsor_r  <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (annul) begin
            state_r <= DC_IDLE;
        end else begin
            case (state_r)
                DC_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state_r <= DC_ZERO;
                        end else begin
                            state_r <= DC_ON;
                            cnt_r   <= '0;
                            rem_r   <= '0;
                            quo_r   <= dividend_mag_s;
                            dsor_r  <= divisor_mag_s;
                            neg_q_r <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                            neg_r_r <= signed_op && dividend[DATA_W-1];
                        end
                    end
                end
                DC_ON: begin
                    if (diff_s[DATA_W] == 1'b0) begin
                        rem_r <= diff_s[DATA_W-1:0];
                        quo_r <= {quo_r[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted_s[DATA_W-1:0];
                        quo_r <= {quo_r[DATA_W-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == CNT_W'(DIV_ITER - 1)) begin
                        state_r <= DC_END;
                    end
                end
                DC_ZERO, DC_END: state_r <= DC_IDLE;
                default:         state_r <= DC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO multi-cycle scheduler beside EX: sequences MULT/MADD/MSUB inline and
// DIV through the iterative divider, stalling the pipe until {HI,LO} is ready.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DIV_ITER = DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_sched_if.slave  bus
);
    localparam int W2 = 2 * DATA_W;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    op_t               op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [W2-1:0]     hilo_r;
    logic [W2-1:0]     prod_r;
    logic [W2-1:0]     result_r;
    logic              ready_r;

    logic              accept_s;
    logic              div_start_s;
    logic              div_ready_s;
    logic [W2-1:0]     div_result_s;
    logic [DATA_W-1:0] mag_a_s;
    logic [DATA_W-1:0] mag_b_s;
    logic              neg_prod_s;
    logic [W2-1:0]     mag_prod_s;
    logic [W2-1:0]     product_s;
    logic [W2-1:0]     acc_s;

    assign accept_s    = (state_r == ST_IDLE) && bus.start_i && !bus.annul_i;
    assign div_start_s = accept_s && is_div_op(bus.op_i);

    // Stall while a request is being accepted or any operation is in flight; never under annul or reset
    assign bus.stallreq_o = (!rst && !bus.annul_i &&
                             (accept_s || (state_r == ST_MUL) || (state_r == ST_ACC) ||
                              (state_r == ST_DIV_ZERO) || (state_r == ST_DIV_ON))) ? STOP : NO_STOP;

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

    muldiv_sched_div_core #(
        .DATA_W   (DATA_W),
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .signed_op (is_signed_op(bus.op_i)),
        .annul     (bus.annul_i),
        .dividend  (bus.opdata1_i),
        .divisor   (bus.opdata2_i),
        .ready     (div_ready_s),
        .result    (div_result_s)
    );

    // Signed multiply via magnitudes and conditional negation, then accumulate/subtract into HI/LO
    always_comb begin
        mag_a_s    = a_r;
        mag_b_s    = b_r;
        neg_prod_s = 1'b0;
        if (is_signed_op(op_r)) begin
            mag_a_s    = a_r[DATA_W-1] ? -a_r : a_r;
            mag_b_s    = b_r[DATA_W-1] ? -b_r : b_r;
            neg_prod_s = a_r[DATA_W-1] ^ b_r[DATA_W-1];
        end else begin
            mag_a_s    = a_r;
            mag_b_s    = b_r;
            neg_prod_s = 1'b0;
        end
        mag_prod_s = W2'(mag_a_s) * W2'(mag_b_s);
        product_s  = neg_prod_s ? -mag_prod_s : mag_prod_s;
        acc_s      = is_sub_op(op_r) ? (hilo_r - prod_r) : (hilo_r + prod_r);
    end

    // Next-state decision; annul forces IDLE from any state
    always_comb begin
        state_nxt_s = state_r;
        if (bus.annul_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if (!is_div_op(bus.op_i)) begin
                            state_nxt_s = ST_MUL;
                        end else if (bus.opdata2_i == '0) begin
                            state_nxt_s = ST_DIV_ZERO;
                        end else begin
                            state_nxt_s = ST_DIV_ON;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MUL:  state_nxt_s = is_acc_op(op_r) ? ST_ACC : ST_DONE;
                ST_ACC:  state_nxt_s = ST_DONE;
                ST_DIV_ZERO, ST_DIV_ON: begin
                    if (div_ready_s == DIV_RESULT_READY) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_DONE: state_nxt_s = bus.start_i ? ST_DONE : ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State and ready flag; ready is high exactly while in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Request capture at acceptance and result/product registers; annul leaves result_o untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_MULT;
            a_r      <= '0;
            b_r      <= '0;
            hilo_r   <= '0;
            prod_r   <= '0;
            result_r <= '0;
        end else begin
            if (accept_s) begin
                op_r   <= bus.op_i;
                a_r    <= bus.opdata1_i;
                b_r    <= bus.opdata2_i;
                hilo_r <= bus.hilo_i;
            end
            if (!bus.annul_i) begin
                case (state_r)
                    ST_MUL: begin
                        if (is_acc_op(op_r)) begin
                            prod_r <= product_s;
                        end else begin
                            result_r <= product_s;
                        end
                    end
                    ST_ACC: result_r <= acc_s;
                    ST_DIV_ZERO, ST_DIV_ON: begin
                        if (div_ready_s == DIV_RESULT_READY) begin
                            result_r <= div_result_s;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: scoreboard of expected {HI,LO} and latency,
// plus annul, start-held-in-DONE and asynchronous reset scenarios.
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_sched_if #(.DATA_W(32)) bus ();

    muldiv_sched #(.DATA_W(32), .DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_res_q[$];
    int          exp_lat_q[$];
    logic [63:0] last_res;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge, wait for ready, hold start one cycle in DONE, release.
    task automatic run_op(input string tag, input op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, input logic [63:0] exp_res, input int exp_lat);
        int          lat;
        logic        stall_ok;
        logic [63:0] e_res;
        int          e_lat;
        exp_res_q.push_back(exp_res);
        exp_lat_q.push_back(exp_lat);
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.hilo_i    = h;
        #1;
        check({tag, "_stall_accept"}, 64'(bus.stallreq_o), 64'd1);
        @(posedge clk);
        #1;
        bus.op_i      = ~op;
        bus.opdata1_i = ~a;
        bus.opdata2_i = 32'h0000_0000;
        bus.hilo_i    = ~h;
        lat      = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        while ((bus.ready_o !== 1'b1) && (lat < 100)) begin
            if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        e_res = exp_res_q.pop_front();
        e_lat = exp_lat_q.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e_lat));
        check({tag, "_result"}, bus.result_o, e_res);
        check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        check({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
        check({tag, "_hold_result"}, bus.result_o, e_res);
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_idle_result"}, bus.result_o, e_res);
        last_res = e_res;
    endtask

    initial begin
        logic seen_ready;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.op_i      = OP_MULT;
        bus.opdata1_i = 32'h0000_0000;
        bus.opdata2_i = 32'h0000_0000;
        bus.hilo_i    = 64'h0;
        bus.annul_i   = 1'b0;
        last_res      = 64'h0;
        repeat (2) @(negedge clk);
        check("reset_result", bus.result_o, 64'h0);
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_stall", 64'(bus.stallreq_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 64'h0, 64'h00000002_0000000E, 33);
        run_op("div_m7_2",    OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'h0, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_op("div_7_m2",    OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0, 64'h00000001_FFFFFFFD, 33);
        run_op("div_by_zero", OP_DIV, 32'h0000_1234, 32'd0, 64'h0, 64'h0, 1);
        run_op("div_minint",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h00000000_80000000, 33);
        run_op("divu_max_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 64'h0, 64'h0000000F_0FFFFFFF, 33);
        run_op("mult_minint", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h40000000_00000000, 1);
        run_op("multu_max_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0, 64'h00000001_FFFFFFFE, 1);
        run_op("madd",        OP_MADD, 32'hFFFF_FFFE, 32'd3, 64'h10, 64'h00000000_0000000A, 2);
        run_op("msubu",       OP_MSUBU, 32'd1, 32'd1, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 2);
        run_op("msub",        OP_MSUB, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 64'h64, 64'h00000000_00000058, 2);
        run_op("maddu_wrap",  OP_MADDU, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 2);

        // Annul in the middle of a divide: no completion, result_o keeps the previous value
        bus.start_i   = 1'b1;
        bus.op_i      = OP_DIVU;
        bus.opdata1_i = 32'hFFFF_FFF0;
        bus.opdata2_i = 32'd3;
        @(posedge clk);
        #1;
        repeat (9) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        #1;
        check("annul_stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        check("annul_ready", 64'(bus.ready_o), 64'd0);
        check("annul_result", bus.result_o, last_res);
        bus.annul_i = 1'b0;
        #1;
        check("annul_idle_stall", 64'(bus.stallreq_o), 64'd0);
        seen_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) seen_ready = 1'b1;
        end
        check("annul_no_ready", 64'(seen_ready), 64'd0);
        check("annul_result_kept", bus.result_o, last_res);

        // Simultaneous start and annul in IDLE: request must not be taken
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        bus.op_i      = OP_MULTU;
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd5;
        #1;
        check("start_annul_stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("start_annul_no_busy", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        check("start_annul_no_ready", 64'(bus.ready_o), 64'd0);
        check("start_annul_result", bus.result_o, last_res);

        run_op("divu_9_3_after_annul", OP_DIVU, 32'd9, 32'd3, 64'h0, 64'h00000000_00000003, 33);
        run_op("multu_back_to_back", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0, 64'h00000001_00000000, 1);

        // Asynchronous reset in the middle of a divide
        bus.start_i   = 1'b1;
        bus.op_i      = OP_DIVU;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        @(posedge clk);
        #1;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_result", bus.result_o, 64'h0);
        check("rst_mid_ready", 64'(bus.ready_o), 64'd0);
        check("rst_mid_stall", 64'(bus.stallreq_o), 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("multu_after_reset", OP_MULTU, 32'd3, 32'd5, 64'h0, 64'h00000000_0000000F, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
